dds_sweep_nco: RTL and testbench

Parametrised multi-channel direct digital synthesiser and successor to the two-port DDS.
- One shared phase accumulator drives NUM_CH channels. Each channel has its own phase offset, source select and amplitude scale.
- A built-in frequency-sweep engine supports fixed, single-chirp, repeating-sawtooth and triangle modes.
- Configuration loads into shadow registers and takes effect phase-coherently.
- Sits between the AXI register bank and the DAC sample interface.

---
 rtl/dds_pkg.sv | 27 ++
 rtl/dds_sweep_nco_lut.sv | 32 +++
 rtl/dds_sweep_nco.sv | 243 ++++++++++++++++++++++++
 tb/tb_dds_sweep_nco.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared constants for the sweep NCO: sweep modes, FSM encoding,
// datapath latency and the optional dither LFSR polynomial.
package dds_pkg;

  localparam logic [1:0] MODE_FIXED  = 2'd0;
  localparam logic [1:0] MODE_SINGLE = 2'd1;
  localparam logic [1:0] MODE_REPEAT = 2'd2;
  localparam logic [1:0] MODE_TRI    = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FIXED = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } sweep_state_e;

  localparam int PIPE_LAT = 4;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // x^16+x^14+x^13+x^11+1, Fibonacci form
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  function automatic logic lfsr_fb(input logic [15:0] s);
    return ^(s & LFSR_TAPS);
  endfunction

endpackage

// File: rtl/dds_sweep_nco_lut.sv
// Waveform table: one write port, one registered read port.
// A same-address read during a write returns the old word.
module dds_lut_ram
  import dds_pkg::*;
#(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rdata_q <= '0;
    else     rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dds_sweep_nco.sv
// Multi-channel sweep NCO: shared accumulator, sweep FSM, per-channel
// LUT/scale pipeline. Define DDS_DITHER_EN to add LFSR phase dither.
module dds_sweep_nco
  import dds_pkg::*;
#(
  parameter int NUM_CH  = 2,
  parameter int PHASE_W = 32,
  parameter int LUT_AW  = 10,
  parameter int DATA_W  = 16,
  parameter int DWELL_W = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      cfg_load,
  input  logic [1:0]                cfg_mode,
  input  logic [PHASE_W-1:0]        cfg_freq_start,
  input  logic [PHASE_W-1:0]        cfg_freq_step,
  input  logic [PHASE_W-1:0]        cfg_freq_stop,
  input  logic [DWELL_W-1:0]        cfg_dwell,
  input  logic [NUM_CH*PHASE_W-1:0] ch_phase,
  input  logic [NUM_CH*DATA_W-1:0]  ch_ampl,
  input  logic [NUM_CH-1:0]         ch_src_sel,
  input  logic [NUM_CH*DATA_W-1:0]  ch_direct,
  input  logic                      lut_we,
  input  logic [LUT_AW-1:0]         lut_addr,
  input  logic [DATA_W-1:0]         lut_wdata,
  output logic [NUM_CH*DATA_W-1:0]  sample_out,
  output logic                      sample_valid,
  output logic [PHASE_W-1:0]        cur_freq,
  output logic                      sweep_busy,
  output logic                      sweep_done,
  output logic                      sweep_wrap
);

  localparam logic signed [DATA_W-1:0] SMIN =
    {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W-1:0] SMAX =
    {1'b0, {(DATA_W-1){1'b1}}};

  logic [1:0]         sh_mode_q;
  logic [PHASE_W-1:0] sh_start_q;
  logic [PHASE_W-1:0] sh_step_q;
  logic [PHASE_W-1:0] sh_stop_q;
  logic [DWELL_W-1:0] sh_dwell_q;

  sweep_state_e       st_q;
  logic [PHASE_W-1:0] cur_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               dn_q;
  logic               done_q;
  logic               wrap_q;

  logic [PHASE_W:0]   up_sum;
  logic [PHASE_W:0]   dn_dif;
  logic               hit_up;
  logic               hit_dn;

  logic [PHASE_W-1:0] acc_q;
  logic               en_q;
  logic [PIPE_LAT-1:0] vld_q;
  logic [PHASE_W-1:0] dith;

  // Extra bit keeps the compare correct across wrap of the word
  always_comb begin
    up_sum = {1'b0, cur_q} + {1'b0, sh_step_q};
    dn_dif = {1'b0, cur_q} - {1'b0, sh_step_q};
    hit_up = up_sum >= {1'b0, sh_stop_q};
    hit_dn = dn_dif[PHASE_W] ||
             (dn_dif[PHASE_W-1:0] <= sh_start_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_mode_q  <= '0;
      sh_start_q <= '0;
      sh_step_q  <= '0;
      sh_stop_q  <= '0;
      sh_dwell_q <= '0;
      st_q       <= ST_IDLE;
      cur_q      <= '0;
      dwell_q    <= '0;
      dn_q       <= 1'b0;
      done_q     <= 1'b0;
      wrap_q     <= 1'b0;
    end else begin
      wrap_q <= 1'b0;
      if (cfg_load) begin
        sh_mode_q  <= cfg_mode;
        sh_start_q <= cfg_freq_start;
        sh_step_q  <= cfg_freq_step;
        sh_stop_q  <= cfg_freq_stop;
        sh_dwell_q <= cfg_dwell;
      end
      if (!en) begin
        st_q    <= ST_IDLE;
        cur_q   <= cfg_load ? cfg_freq_start : sh_start_q;
        dwell_q <= '0;
        dn_q    <= 1'b0;
        done_q  <= 1'b0;
      end else if (cfg_load) begin
        st_q    <= (cfg_mode == MODE_FIXED) ? ST_FIXED : ST_RUN;
        cur_q   <= cfg_freq_start;
        dwell_q <= '0;
        dn_q    <= 1'b0;
        done_q  <= 1'b0;
      end else begin
        unique case (st_q)
          ST_IDLE: begin
            st_q    <= (sh_mode_q == MODE_FIXED) ? ST_FIXED : ST_RUN;
            cur_q   <= sh_start_q;
            dwell_q <= '0;
          end
          ST_RUN: begin
            if (dwell_q != sh_dwell_q) begin
              dwell_q <= dwell_q + 1'b1;
            end else begin
              dwell_q <= '0;
              if (dn_q) begin
                if (hit_dn) begin
                  cur_q  <= sh_start_q;
                  dn_q   <= 1'b0;
                  wrap_q <= 1'b1;
                end else begin
                  cur_q <= dn_dif[PHASE_W-1:0];
                end
              end else if (!hit_up) begin
                cur_q <= up_sum[PHASE_W-1:0];
              end else if (sh_mode_q == MODE_SINGLE) begin
                cur_q  <= sh_stop_q;
                st_q   <= ST_DONE;
                done_q <= 1'b1;
              end else if (sh_mode_q == MODE_REPEAT) begin
                cur_q  <= sh_start_q;
                wrap_q <= 1'b1;
              end else begin
                cur_q  <= sh_stop_q;
                dn_q   <= 1'b1;
                wrap_q <= 1'b1;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      en_q  <= 1'b0;
      vld_q <= '0;
    end else if (!en) begin
      acc_q <= '0;
      en_q  <= 1'b0;
      vld_q <= '0;
    end else begin
      acc_q <= acc_q + cur_q;
      en_q  <= 1'b1;
      vld_q <= {vld_q[PIPE_LAT-2:0], en_q};
    end
  end

`ifdef DDS_DITHER_EN
  localparam int DIT_W =
    ((PHASE_W - LUT_AW) < 16) ? (PHASE_W - LUT_AW) : 16;

  logic [15:0] lfsr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     lfsr_q <= LFSR_SEED;
    else if (en) lfsr_q <= {lfsr_q[14:0], lfsr_fb(lfsr_q)};
  end

  always_comb begin
    dith = '0;
    dith[DIT_W-1:0] = lfsr_q[DIT_W-1:0];
  end
`else
  assign dith = '0;
`endif

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    logic [PHASE_W-1:0]        off;
    logic signed [DATA_W-1:0]  amp;
    logic signed [DATA_W-1:0]  dir;
    logic [PHASE_W-1:0]        ph_q;
    logic [DATA_W-1:0]         rd;
    logic signed [DATA_W-1:0]  mux_q;
    logic signed [DATA_W-1:0]  out_q;
    logic signed [2*DATA_W-1:0] prod;
    logic                      sat;
    logic                      unused_bits;

    assign off = ch_phase[k*PHASE_W +: PHASE_W];
    assign amp = ch_ampl[k*DATA_W +: DATA_W];
    assign dir = ch_direct[k*DATA_W +: DATA_W];

    dds_lut_ram #(
      .AW (LUT_AW),
      .DW (DATA_W)
    ) u_lut (
      .clk     (clk),
      .rst     (rst),
      .we_i    (lut_we),
      .waddr_i (lut_addr),
      .wdata_i (lut_wdata),
      .raddr_i (ph_q[PHASE_W-1 -: LUT_AW]),
      .rdata_o (rd)
    );

    assign prod = (2*DATA_W)'(mux_q) * (2*DATA_W)'(amp);
    // Full-scale negative squared is the only product that overflows
    assign sat  = (mux_q == SMIN) && (amp == SMIN);

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        ph_q  <= '0;
        mux_q <= '0;
        out_q <= '0;
      end else begin
        ph_q  <= acc_q + off + dith;
        mux_q <= ch_src_sel[k] ? rd : dir;
        out_q <= sat ? SMAX : prod[2*DATA_W-2 -: DATA_W];
      end
    end

    assign unused_bits = ^{ph_q[PHASE_W-LUT_AW-1:0],
                           prod[2*DATA_W-1],
                           prod[DATA_W-2:0]};

    assign sample_out[k*DATA_W +: DATA_W] = out_q;
  end

  assign sample_valid = vld_q[PIPE_LAT-1];
  assign cur_freq     = cur_q;
  assign sweep_busy   = (st_q == ST_RUN);
  assign sweep_done   = done_q;
  assign sweep_wrap   = wrap_q;

endmodule

// File: tb/tb_dds_sweep_nco.sv
// Randomised bench for dds_sweep_nco against a cycle-level
// behavioural model of sweep, accumulator and scaled samples.
module tb_dds_sweep_nco;

  localparam int NCH = 2;
  localparam int PW  = 32;
  localparam int AW  = 10;
  localparam int DW  = 16;
  localparam int WW  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              en;
  logic              cfg_load;
  logic [1:0]        cfg_mode;
  logic [PW-1:0]     cfg_freq_start;
  logic [PW-1:0]     cfg_freq_step;
  logic [PW-1:0]     cfg_freq_stop;
  logic [WW-1:0]     cfg_dwell;
  logic [NCH*PW-1:0] ch_phase;
  logic [NCH*DW-1:0] ch_ampl;
  logic [NCH-1:0]    ch_src_sel;
  logic [NCH*DW-1:0] ch_direct;
  logic              lut_we;
  logic [AW-1:0]     lut_addr;
  logic [DW-1:0]     lut_wdata;
  logic [NCH*DW-1:0] sample_out;
  logic              sample_valid;
  logic [PW-1:0]     cur_freq;
  logic              sweep_busy;
  logic              sweep_done;
  logic              sweep_wrap;

  dds_sweep_nco #(
    .NUM_CH  (NCH),
    .PHASE_W (PW),
    .LUT_AW  (AW),
    .DATA_W  (DW),
    .DWELL_W (WW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .en             (en),
    .cfg_load       (cfg_load),
    .cfg_mode       (cfg_mode),
    .cfg_freq_start (cfg_freq_start),
    .cfg_freq_step  (cfg_freq_step),
    .cfg_freq_stop  (cfg_freq_stop),
    .cfg_dwell      (cfg_dwell),
    .ch_phase       (ch_phase),
    .ch_ampl        (ch_ampl),
    .ch_src_sel     (ch_src_sel),
    .ch_direct      (ch_direct),
    .lut_we         (lut_we),
    .lut_addr       (lut_addr),
    .lut_wdata      (lut_wdata),
    .sample_out     (sample_out),
    .sample_valid   (sample_valid),
    .cur_freq       (cur_freq),
    .sweep_busy     (sweep_busy),
    .sweep_done     (sweep_done),
    .sweep_wrap     (sweep_wrap)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // channel settings
  bit [31:0]    chph [NCH];
  bit [15:0]    amp  [NCH];
  bit [15:0]    dir  [NCH];
  bit [NCH-1:0] sel;

  // reference model
  bit [15:0] lut_m [1024];
  bit [1:0]  sh_mode;
  bit [31:0] sh_start, sh_step, sh_stop;
  bit [15:0] sh_dwell;
  bit [31:0] m_cur, m_acc;
  int        m_cnt, en_run;
  bit        m_started, m_run, m_done, m_down, m_wrap;
  bit [31:0] hist [$];

  task automatic m_reset();
    sh_mode = 0; sh_start = 0; sh_step = 0; sh_stop = 0; sh_dwell = 0;
    m_cur = 0; m_acc = 0; m_cnt = 0; en_run = 0;
    m_started = 0; m_run = 0; m_done = 0; m_down = 0; m_wrap = 0;
    hist.delete();
  endtask

  task automatic take_step();
    longint n;
    if (!m_down) begin
      n = longint'(m_cur) + longint'(sh_step);
      if (n < longint'(sh_stop)) m_cur = n[31:0];
      else if (sh_mode == 2'd1) begin
        m_cur = sh_stop; m_run = 0; m_done = 1;
      end else if (sh_mode == 2'd2) begin
        m_cur = sh_start; m_wrap = 1;
      end else begin
        m_cur = sh_stop; m_down = 1; m_wrap = 1;
      end
    end else begin
      n = longint'(m_cur) - longint'(sh_step);
      if (n > longint'(sh_start)) m_cur = n[31:0];
      else begin
        m_cur = sh_start; m_down = 0; m_wrap = 1;
      end
    end
  endtask

  // advance the model across one clock edge using current inputs
  task automatic model_edge();
    bit [31:0] old;
    old = m_cur;
    m_wrap = 0;
    if (lut_we) lut_m[lut_addr] = lut_wdata;
    if (cfg_load) begin
      sh_mode = cfg_mode; sh_start = cfg_freq_start;
      sh_step = cfg_freq_step; sh_stop = cfg_freq_stop;
      sh_dwell = cfg_dwell;
    end
    if (!en) begin
      m_cur = sh_start; m_started = 0; m_run = 0;
      m_done = 0; m_down = 0; m_cnt = 0;
    end else if (cfg_load || !m_started) begin
      m_cur = sh_start; m_started = 1; m_run = (sh_mode != 0);
      m_done = 0; m_down = 0; m_cnt = 0;
    end else if (m_run) begin
      m_cnt++;
      if (m_cnt == int'(sh_dwell) + 1) begin
        m_cnt = 0;
        take_step();
      end
    end
    m_acc = en ? m_acc + old : 32'd0;
    hist.push_back(m_acc);
    if (hist.size() > 8) void'(hist.pop_front());
    en_run = en ? en_run + 1 : 0;
  endtask

  function automatic bit [15:0] exp_smp(int k, bit [31:0] a);
    bit [31:0]        ph;
    bit [9:0]         ad;
    bit signed [15:0] d, g;
    longint           p;
    ph = a + chph[k];
    ad = ph[31:22];
    d  = sel[k] ? lut_m[ad] : dir[k];
    g  = amp[k];
    if (d == 16'sh8000 && g == 16'sh8000) return 16'h7FFF;
    p = longint'(d) * longint'(g);
    p = p >>> 15;
    return p[15:0];
  endfunction

  task automatic compare();
    chk("cur_freq", cur_freq, m_cur);
    chk("busy", sweep_busy, m_run);
    chk("done", sweep_done, m_done);
    chk("wrap", sweep_wrap, m_wrap);
    chk("valid", sample_valid, en_run >= 5);
    if (en_run >= 5)
      for (int k = 0; k < NCH; k++)
        chk($sformatf("smp%0d", k), sample_out[k*DW +: DW],
            exp_smp(k, hist[hist.size()-5]));
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic apply_ch();
    for (int k = 0; k < NCH; k++) begin
      ch_phase[k*PW +: PW]  = chph[k];
      ch_ampl[k*DW +: DW]   = amp[k];
      ch_direct[k*DW +: DW] = dir[k];
    end
    ch_src_sel = sel;
  endtask

  task automatic set_cfg(input bit [1:0] md, input bit [31:0] st,
                         input bit [31:0] sp, input bit [31:0] se,
                         input bit [15:0] dw);
    cfg_mode = md; cfg_freq_start = st; cfg_freq_step = sp;
    cfg_freq_stop = se; cfg_dwell = dw;
  endtask

  task automatic run_seg(input bit [1:0] md, input bit [31:0] st,
                         input bit [31:0] sp, input bit [31:0] se,
                         input bit [15:0] dw, input int n);
    en = 0;
    tick();
    apply_ch();
    set_cfg(md, st, sp, se, dw);
    cfg_load = 1;
    tick();
    cfg_load = 0;
    en = 1;
    repeat (n) tick();
  endtask

  task automatic rand_cfg();
    if ($urandom_range(0, 3) == 0)
      set_cfg(2'($urandom_range(0, 3)), $urandom, $urandom,
              $urandom, 16'($urandom_range(0, 5)));
    else
      set_cfg(2'($urandom_range(0, 3)), $urandom_range(0, 'h3000),
              $urandom_range(0, 'h400), $urandom_range(0, 'h4000),
              16'($urandom_range(0, 5)));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  initial begin
    rst = 1; en = 0; cfg_load = 0; lut_we = 0;
    lut_addr = '0; lut_wdata = '0;
    set_cfg(0, 0, 0, 0, 0);
    for (int k = 0; k < NCH; k++) begin
      chph[k] = 0; amp[k] = 0; dir[k] = 0;
    end
    sel = '0;
    apply_ch();
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    chk("rst_smp", sample_out, 0);
    chk("rst_cur", cur_freq, 0);
    chk("rst_valid", sample_valid, 0);
    tick();

    // LUT ramp: entry i holds i*64
    lut_we = 1;
    for (int i = 0; i < 1024; i++) begin
      lut_addr = AW'(i);
      lut_wdata = DW'(i * 64);
      tick();
    end
    lut_we = 0;

    // fixed quarter-rate tone, ch1 a quarter cycle ahead
    chph[0] = 0; chph[1] = 32'h4000_0000;
    amp[0] = 16'h7FFF; amp[1] = 16'h7FFF; sel = 2'b11;
    run_seg(0, 32'h4000_0000, 0, 0, 0, 20);

    // asynchronous reset in the middle of a run
    #2 rst = 1;
    #1;
    chk("arst_smp", sample_out, 0);
    chk("arst_cur", cur_freq, 0);
    chk("arst_valid", sample_valid, 0);
    chk("arst_busy", sweep_busy, 0);
    m_reset();
    @(posedge clk);
    #1 rst = 0;
    set_cfg(0, 32'h4000_0000, 0, 0, 0);
    cfg_load = 1;
    tick();
    cfg_load = 0;
    repeat (12) tick();

    // single, repeat and triangle sweeps
    run_seg(1, 32'h100, 32'h100, 32'h400, 3, 30);
    run_seg(2, 32'h100, 32'h100, 32'h400, 3, 40);
    run_seg(3, 32'h100, 32'h100, 32'h400, 3, 50);

    // coherent reload mid-sweep, then load against a due step
    run_seg(1, 32'h100, 32'h100, 32'h400, 3, 6);
    set_cfg(1, 32'h800, 32'h100, 32'h1000, 3);
    cfg_load = 1;
    tick();
    cfg_load = 0;
    chk("reload_cur", cur_freq, 32'h800);
    repeat (40) tick();
    chk("sweep_end", sweep_done, 1);
    cfg_load = 1;
    tick();
    cfg_load = 0;
    chk("reload_clr", sweep_done, 0);
    repeat (3) tick();
    set_cfg(1, 32'h2000, 32'h100, 32'h3000, 3);
    cfg_load = 1;
    tick();
    cfg_load = 0;
    chk("load_wins", cur_freq, 32'h2000);
    repeat (5) tick();

    // direct path and saturation
    chph[0] = 0; chph[1] = 0; sel = 2'b00;
    dir[0] = 16'h8000; amp[0] = 16'h8000;
    dir[1] = 16'h4000; amp[1] = 16'h7FFF;
    run_seg(0, 32'h1000, 0, 0, 0, 8);
    chk("sat", sample_out[15:0], 16'h7FFF);
    chk("half", sample_out[31:16], 16'h3FFF);
    amp[1] = 16'hC000;
    run_seg(0, 32'h1000, 0, 0, 0, 8);
    chk("neg", sample_out[31:16], 16'hE000);

    // randomised segments
    for (int s = 0; s < 25; s++) begin
      en = 0;
      lut_we = 1;
      repeat (20) begin
        lut_addr = AW'($urandom);
        lut_wdata = DW'($urandom);
        tick();
      end
      lut_we = 0;
      for (int k = 0; k < NCH; k++) begin
        chph[k] = $urandom;
        amp[k] = 16'($urandom);
        dir[k] = 16'($urandom);
        if ($urandom_range(0, 7) == 0) begin
          amp[k] = 16'h8000; dir[k] = 16'h8000;
        end
      end
      sel = NCH'($urandom);
      apply_ch();
      rand_cfg();
      cfg_load = 1;
      tick();
      cfg_load = 0;
      en = 1;
      for (int c = 0; c < int'($urandom_range(30, 80)); c++) begin
        cfg_load = ($urandom_range(0, 24) == 0);
        if (cfg_load) rand_cfg();
        en = ($urandom_range(0, 59) != 0);
        tick();
      end
      cfg_load = 0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
